// File: rtl/noc_tree_pkg.sv
// Shared NoC tree definitions: packet/address defaults, output port indices,
// output-stage state encoding and the destination route decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package noc_tree_pkg;

  localparam int WIDTH_PACKET_DEF = 14;
  localparam int ADDR_W_DEF       = 4;
  localparam int NUM_PORTS        = 3;

  localparam int PORT_LEFT   = 0;
  localparam int PORT_RIGHT  = 1;
  localparam int PORT_PARENT = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } outState_e;

  // One-hot port for a destination leaf address. The top `level` address bits
  // must match this router's prefix, otherwise the packet climbs to the parent.
  // Inside the subtree, the next address bit below the prefix picks the child.
  // The root (level 0) has no prefix, so it can never pick the parent.
  function automatic logic [2:0] routeDecode(input logic [31:0] dst,
                                             input int level,
                                             input int prefix,
                                             input int addrW);
    logic [31:0] mask;
    logic [31:0] upper;
    logic [2:0]  oneHot;
    oneHot = '0;
    mask   = (32'd1 << level) - 32'd1;
    upper  = (dst >> (addrW - level)) & mask;
    if ((level != 0) && (upper != (32'(prefix) & mask))) begin
      oneHot[PORT_PARENT] = 1'b1;
    end else if (dst[addrW-1-level]) begin
      oneHot[PORT_RIGHT] = 1'b1;
    end else begin
      oneHot[PORT_LEFT] = 1'b1;
    end
    return oneHot;
  endfunction

endpackage

// File: rtl/noc_input_ctrl_if.sv
// Packet handshake bundle between link receiver, input control and output arbiters.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready carry it; slave is the input control stage.
// Ports: in_data/in_valid/in_ready (upstream side), out_data/out_valid/out_ready
// (one-hot request towards left/right/parent arbiters).
interface noc_input_ctrl_if
  import noc_tree_pkg::*;
#(
  parameter int WIDTH_packet = WIDTH_PACKET_DEF
);
  logic [WIDTH_packet-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH_packet-1:0] out_data;
  logic [NUM_PORTS-1:0]    out_valid;
  logic [NUM_PORTS-1:0]    out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/icm_fifo.sv
// Synchronous FIFO buffering packets ahead of the route decode.
// Latency: written word visible at popData the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
// Ports: clk, reset (async active-high), push/pushData, pop/popData (head, combinational),
// full, empty, count.
module icm_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign popData = mem[rdPtr];

  // Storage needs no reset: nothing is read from an entry before it is written.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_ctrl.sv
// NoC tree router input control: FIFO-buffered packets routed to left/right/parent.
// Latency: packet pushed at edge k into an empty block is presented after edge k+1.
// Backpressure: packet held in HOLD until its selected out_ready; in_ready = FIFO not full.
// Ports: clk, reset (async active-high), io (noc_input_ctrl_if.slave),
// pkt_cnt[47:0] per-port handshake counters {parent, right, left} when ICM_PKT_CNT_EN is defined.
module noc_input_ctrl
  import noc_tree_pkg::*;
#(
  parameter int WIDTH_packet = WIDTH_PACKET_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int LEVEL        = 1,
  parameter int NODE_PREFIX  = 0,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  noc_input_ctrl_if.slave   io
`ifdef ICM_PKT_CNT_EN
  ,
  output logic [47:0]       pkt_cnt
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [WIDTH_packet-1:0] headData;
  logic                    fifoFull;
  logic                    fifoEmpty;
  logic [CNT_W-1:0]        fifoCount;
  logic                    doPush;
  logic                    doPop;
  logic [ADDR_W-1:0]       headDst;
  logic [NUM_PORTS-1:0]    headPort;

  outState_e               state;
  outState_e               nextState;
  logic [WIDTH_packet-1:0] outData;
  logic [NUM_PORTS-1:0]    outPort;
  logic                    handshake;

  // Readiness comes only from registered occupancy; reset forces it low so the
  // upstream sees no acceptance while the block is being cleared.
  assign io.in_ready = (fifoCount != CNT_W'(FIFO_DEPTH)) & ~reset;
  assign doPush      = io.in_valid & ~fifoFull;

  icm_fifo #(
    .WIDTH (WIDTH_packet),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (doPush),
    .pushData (io.in_data),
    .pop      (doPop),
    .popData  (headData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign headDst  = headData[WIDTH_packet-1 -: ADDR_W];
  assign headPort = routeDecode(32'(headDst), LEVEL, NODE_PREFIX, ADDR_W);

  // Only the selected port's ready can complete the transfer.
  assign handshake = (state == ST_HOLD) && ((outPort & io.out_ready) != '0);

  always_comb begin
    nextState = state;
    doPop     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (!fifoEmpty) begin
          doPop     = 1'b1;
          nextState = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (handshake) begin
          if (!fifoEmpty) begin
            doPop = 1'b1;
          end else begin
            nextState = ST_EMPTY;
          end
        end
      end
      default: nextState = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_EMPTY;
      outData <= '0;
      outPort <= '0;
    end else begin
      state <= nextState;
      if (doPop) begin
        outData <= headData;
        outPort <= headPort;
      end
    end
  end

  assign io.out_data  = outData;
  assign io.out_valid = (state == ST_HOLD) ? outPort : '0;

`ifdef ICM_PKT_CNT_EN
  logic [15:0] portCnt [NUM_PORTS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) portCnt[i] <= '0;
    end else if (handshake) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (outPort[i]) portCnt[i] <= portCnt[i] + 16'd1;
      end
    end
  end

  assign pkt_cnt = {portCnt[PORT_PARENT], portCnt[PORT_RIGHT], portCnt[PORT_LEFT]};
`endif

endmodule

// File: tb/tb_noc_input_ctrl.sv
// Self-checking bench for noc_input_ctrl: LEVEL=1 instance plus a LEVEL=0 (root) instance.
// Expected packets/ports are queued at push time and compared on each output handshake.
// Optional pkt_cnt checks are compiled in when ICM_PKT_CNT_EN is defined.
module tb_noc_input_ctrl;
  import noc_tree_pkg::*;

  typedef struct packed {
    logic [13:0] d;
    logic [2:0]  p;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  noc_input_ctrl_if #(.WIDTH_packet(14)) io1 ();
  noc_input_ctrl_if #(.WIDTH_packet(14)) io0 ();

`ifdef ICM_PKT_CNT_EN
  logic [47:0] pktCnt1;
  logic [47:0] pktCnt0;
`endif

  noc_input_ctrl #(
    .WIDTH_packet (14), .ADDR_W (4), .LEVEL (1), .NODE_PREFIX (0), .FIFO_DEPTH (2)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .io    (io1)
`ifdef ICM_PKT_CNT_EN
    , .pkt_cnt (pktCnt1)
`endif
  );

  noc_input_ctrl #(
    .WIDTH_packet (14), .ADDR_W (4), .LEVEL (0), .NODE_PREFIX (0), .FIFO_DEPTH (2)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .io    (io0)
`ifdef ICM_PKT_CNT_EN
    , .pkt_cnt (pktCnt0)
`endif
  );

  int   vecCnt = 0;
  int   errCnt = 0;
  int   cyc    = 0;
  exp_t q1 [$];
  exp_t q0 [$];
  int   hsLog [$];
  int   expCnt [3];
  exp_t e1;
  exp_t e0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
    vecCnt++;
    if (got !== want) begin
      errCnt++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Independent routing model for prefix 0: level 1 sends dst[3]=1 upward,
  // otherwise dst[2] picks the child; the root uses dst[3] directly.
  function automatic logic [2:0] tbRoute(input logic [13:0] pkt, input int level);
    logic [3:0] dst;
    dst = pkt[13:10];
    if (level == 0) return dst[3] ? 3'b010 : 3'b001;
    if (dst[3]) return 3'b100;
    return dst[2] ? 3'b010 : 3'b001;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset && ((io1.out_valid & io1.out_ready) != 3'b000)) begin
      hsLog.push_back(cyc);
      if (q1.size() == 0) begin
        checkVal("dut1_spurious_vld", 64'(io1.out_valid), 64'd0);
      end else begin
        e1 = q1.pop_front();
        checkVal("dut1_port", 64'(io1.out_valid), 64'(e1.p));
        checkVal("dut1_data", 64'(io1.out_data), 64'(e1.d));
        for (int i = 0; i < 3; i++) if (e1.p[i]) expCnt[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ((io0.out_valid & io0.out_ready) != 3'b000)) begin
      if (q0.size() == 0) begin
        checkVal("dut0_spurious_vld", 64'(io0.out_valid), 64'd0);
      end else begin
        e0 = q0.pop_front();
        checkVal("dut0_port", 64'(io0.out_valid), 64'(e0.p));
        checkVal("dut0_data", 64'(io0.out_data), 64'(e0.d));
      end
    end
  end

  // Called just after a rising edge; leaves in_valid high so calls chain back-to-back.
  task automatic push1(input logic [13:0] d);
    int n;
    n = 0;
    io1.in_data  = d;
    io1.in_valid = 1'b1;
    @(negedge clk);
    while (!io1.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!io1.in_ready) checkVal("push_timeout_rdy", 64'(io1.in_ready), 64'd1);
    else q1.push_back('{d: d, p: tbRoute(d, 1)});
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain1();
    int n;
    n = 0;
    while (q1.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkVal("dut1_drain", 64'(q1.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] rnd;
    logic [13:0] rootPkts [4];
    int n;
    rootPkts[0] = 14'h2000; rootPkts[1] = 14'h0600;
    rootPkts[2] = 14'h1000; rootPkts[3] = 14'h3C00;
    for (int i = 0; i < 3; i++) expCnt[i] = 0;

    reset = 1'b1;
    io1.in_valid = 1'b0; io1.in_data = '0; io1.out_ready = 3'b000;
    io0.in_valid = 1'b0; io0.in_data = '0; io0.out_ready = 3'b000;

    // Reset state.
    #12;
    checkVal("rst_out_valid", 64'(io1.out_valid), 64'd0);
    checkVal("rst_out_data", 64'(io1.out_data), 64'd0);
    checkVal("rst_in_ready", 64'(io1.in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkVal("post_rst_in_ready", 64'(io1.in_ready), 64'd1);
    checkVal("post_rst_out_valid", 64'(io1.out_valid), 64'd0);

    // Latency and the three routing directions.
    io1.out_ready = 3'b111;
    push1(14'h0600);
    io1.in_valid = 1'b0;
    checkVal("lat_early_vld", 64'(io1.out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkVal("lat_vld", 64'(io1.out_valid), 64'b001);
    checkVal("lat_dat", 64'(io1.out_data), 64'h0600);
    push1(14'h1000);
    push1(14'h2000);
    io1.in_valid = 1'b0;
    waitDrain1();

    // Backpressure: only non-selected readies asserted, FIFO fills behind HOLD.
    io1.out_ready = 3'b110;
    push1(14'h0600);
    push1(14'h1400);
    push1(14'h2C00);
    io1.in_valid = 1'b0;
    checkVal("bp_in_ready_low", 64'(io1.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkVal("bp_hold_vld", 64'(io1.out_valid), 64'b001);
      checkVal("bp_hold_dat", 64'(io1.out_data), 64'h0600);
    end
    hsLog.delete();
    io1.out_ready = 3'b111;
    waitDrain1();
    checkVal("bp_release_cnt", 64'(hsLog.size()), 64'd3);
    checkVal("bp_release_span", 64'(hsLog[hsLog.size()-1] - hsLog[0]), 64'd2);

    // Back-to-back random traffic at full throughput.
    hsLog.delete();
    for (int i = 0; i < 8; i++) begin
      rnd = 14'($urandom);
      push1(rnd);
    end
    io1.in_valid = 1'b0;
    waitDrain1();
    checkVal("b2b_cnt", 64'(hsLog.size()), 64'd8);
    checkVal("b2b_span", 64'(hsLog[hsLog.size()-1] - hsLog[0]), 64'd7);

`ifdef ICM_PKT_CNT_EN
    checkVal("cnt_left", 64'(pktCnt1[15:0]), 64'(expCnt[0]));
    checkVal("cnt_right", 64'(pktCnt1[31:16]), 64'(expCnt[1]));
    checkVal("cnt_parent", 64'(pktCnt1[47:32]), 64'(expCnt[2]));
`endif

    // Reset while holding a packet with two queued behind it.
    io1.out_ready = 3'b000;
    push1(14'h0600);
    push1(14'h1000);
    push1(14'h2000);
    io1.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkVal("midrst_out_valid", 64'(io1.out_valid), 64'd0);
    checkVal("midrst_out_data", 64'(io1.out_data), 64'd0);
    checkVal("midrst_in_ready", 64'(io1.in_ready), 64'd0);
    q1.delete();
    for (int i = 0; i < 3; i++) expCnt[i] = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkVal("midrst_rel_in_ready", 64'(io1.in_ready), 64'd1);
    checkVal("midrst_rel_out_valid", 64'(io1.out_valid), 64'd0);
    io1.out_ready = 3'b111;
    repeat (4) @(posedge clk);
    #1;
    checkVal("midrst_no_stale", 64'(io1.out_valid), 64'd0);
    push1(14'h1000);
    io1.in_valid = 1'b0;
    waitDrain1();

`ifdef ICM_PKT_CNT_EN
    checkVal("cnt_after_rst", 64'(pktCnt1), {16'd0, 16'(expCnt[2]), 16'(expCnt[1]), 16'(expCnt[0])});
`endif

    // Root router: never selects parent.
    io0.out_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      checkVal("dut0_in_ready", 64'(io0.in_ready), 64'd1);
      io0.in_data  = rootPkts[i];
      io0.in_valid = 1'b1;
      q0.push_back('{d: rootPkts[i], p: tbRoute(rootPkts[i], 0)});
      @(posedge clk);
      #1;
    end
    io0.in_valid = 1'b0;
    n = 0;
    while (q0.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkVal("dut0_drain", 64'(q0.size()), 64'd0);
    checkVal("dut1_final_empty", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/noc_input_ctrl.md
# noc_input_ctrl

Clocked input control stage of a NoC tree router: takes 14-bit packets from the upstream packet source (generator or neighbouring router link), buffers them in a small FIFO, decodes the destination address and hands each packet to exactly one output port (left child, right child, parent) over a valid/ready handshake. It sits between the link receiver and the router's output arbiters.

## Interface
- WIDTH_packet, 14, packet width; destination address occupies packet[WIDTH_packet-1 -: ADDR_W]
- ADDR_W, 4, leaf address width
- LEVEL, 1, depth of this router in the tree (root = 0); legal range 0..ADDR_W-1
- NODE_PREFIX, 0, top LEVEL address bits identifying this router's subtree (ignored when LEVEL = 0)
- FIFO_DEPTH, 2, input FIFO entries (power of two, >= 2)
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  WIDTH_packet  incoming packet
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO can accept (not full)
- out_data  output  WIDTH_packet  registered packet, shared by all output ports
- out_valid  output  3  one-hot request: [0] left, [1] right, [2] parent
- out_ready  input  3  per-port accept from output arbiters

## Operation
- Push: in_valid & in_ready at a rising edge writes in_data into FIFO tail.
- Route decode of FIFO head dst: if LEVEL > 0 and dst[ADDR_W-1 -: LEVEL] != NODE_PREFIX -> parent; else dst[ADDR_W-1-LEVEL] == 0 -> left, 1 -> right. Root never selects parent.
- Output stage FSM, two states: EMPTY (out_valid = 0) and HOLD (out_valid = one-hot of latched port, out_data stable).
- EMPTY -> HOLD when FIFO non-empty: pop head, latch packet and decoded port.
- HOLD with out_ready[port] = 1: handshake done; if FIFO non-empty, pop and reload (stay HOLD), else -> EMPTY.
- HOLD with out_ready[port] = 0: hold out_data/out_valid unchanged; out_ready on non-selected bits ignored.
- Push and pop in the same edge allowed at any occupancy except full (no push when full).
- Packet order preserved; no packet dropped or duplicated.

## Timing
- Reset (async assert): FIFO count 0, pointers 0, state EMPTY, out_valid = 3'b000, out_data = 0, in_ready = 0 while reset high; in_ready = 1 on first cycle after release.
- in_ready = (count != FIFO_DEPTH), registered-state only; no combinational path from out_ready or in_valid.
- Latency: packet pushed at edge k into empty block appears on out_data/out_valid after edge k+1.
- Throughput: one packet per cycle sustained when out_ready held high.
- Reset asserted mid-transfer: all in-flight packets discarded, outputs clear immediately.

## Configuration
- ICM_PKT_CNT_EN defined: adds output pkt_cnt (48 bits: [15:0] left, [31:16] right, [47:32] parent); each 16-bit counter increments on its port's output handshake, wraps 0xFFFF -> 0x0000, reset to 0.
- Undefined: port and counters absent; all other behaviour identical.

## Structure
- Package noc_tree_pkg: WIDTH_packet and ADDR_W defaults, port index constants PORT_LEFT = 0, PORT_RIGHT = 1, PORT_PARENT = 2, and the route decode function (dst, level, prefix -> one-hot 3-bit).
- Sub-module icm_fifo: synchronous FIFO (push/pop/full/empty/count, async active-high reset); noc_input_ctrl holds decode, output FSM and counters.

## Test plan
- LEVEL=1, NODE_PREFIX=0: send 14'h0600 (dst 0001), out_ready=3'b111 -> out_valid=3'b001, out_data=14'h0600 after edge k+1.
- Same config: 14'h1000 (dst 0100) -> out_valid=3'b010; 14'h2000 (dst 1000) -> out_valid=3'b100.
- LEVEL=0: send 14'h2000 -> out_valid=3'b010 (right), never 3'b100.
- out_ready=0, push 3 packets -> two in FIFO plus one in HOLD... with FIFO_DEPTH=2 in_ready drops to 0 after 3rd accept; release out_ready -> packets emerge in order, one per cycle.
- Back-to-back 8 random packets with out_ready=3'b111 -> 8 outputs on consecutive cycles, order preserved; with ICM_PKT_CNT_EN counts sum to 8.
- Assert reset while HOLD with 2 queued -> out_valid=0 immediately, no stale packet output after release, in_ready=1.
